// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, data-enable and frame markers from a VGA-style
// sync stream, verifying line/frame timing before reporting lock.
module vga_sync_decoder #(
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BACK      = 48,
   parameter int unsigned H_VALID     = 640,
   parameter int unsigned H_TOTAL     = 800,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BACK      = 33,
   parameter int unsigned V_VALID     = 480,
   parameter int unsigned V_TOTAL     = 525,
   parameter bit          SYNC_POL    = 1'b1,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic       vga_clk,
   input  logic       sys_rst,
   input  logic       in_hs,
   input  logic       in_vs,
   input  logic [7:0] in_r,
   input  logic [7:0] in_g,
   input  logic [7:0] in_b,
   output logic [7:0] pix_r,
   output logic [7:0] pix_g,
   output logic [7:0] pix_b,
   output logic       pix_de,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       frame_start,
   output logic       locked,
   output logic       sync_err,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      CHECK    = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   localparam logic [11:0] HA0 = 12'(H_SYNC + H_BACK);
   localparam logic [11:0] HA1 = 12'(H_SYNC + H_BACK + H_VALID);
   localparam logic [11:0] HT  = 12'(H_TOTAL);
   localparam logic [11:0] TMO = 12'(2 * H_TOTAL);
   localparam logic [10:0] VA0 = 11'(V_SYNC + V_BACK);
   localparam logic [10:0] VA1 = 11'(V_SYNC + V_BACK + V_VALID);
   localparam logic [10:0] VT  = 11'(V_TOTAL);
   localparam logic [3:0]  LF  = 4'(LOCK_FRAMES);

   state_t      state;
   logic [3:0]  good_cnt;
   logic        skip_line;
   logic        s1_hs, s2_hs, s1_vs, s2_vs;
   logic [23:0] s1_rgb, s2_rgb;
   logic [11:0] h_cnt;
   logic [10:0] v_cnt;

   logic hs_edge, vs_edge, line_bad, frame_ok, h_active, v_active, de_next;

   always_comb begin
      hs_edge  = s1_hs & ~s2_hs;
      vs_edge  = s1_vs & ~s2_vs;
      // The first line after leaving UNLOCKED started at an unknown point, so its length is not judged.
      line_bad = (hs_edge && !skip_line && ((h_cnt + 12'd1) != HT)) || (h_cnt == TMO);
      frame_ok = ((v_cnt + 11'd1) == VT);
      h_active = (h_cnt >= HA0) && (h_cnt < HA1);
      v_active = (v_cnt >= VA0) && (v_cnt < VA1);
      de_next  = h_active && v_active && (state == LOCKED);
   end

   assign dbg_state = state;

   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         state       <= UNLOCKED;
         good_cnt    <= 4'd0;
         skip_line   <= 1'b1;
         s1_hs       <= 1'b0;
         s2_hs       <= 1'b0;
         s1_vs       <= 1'b0;
         s2_vs       <= 1'b0;
         s1_rgb      <= 24'd0;
         s2_rgb      <= 24'd0;
         h_cnt       <= 12'd0;
         v_cnt       <= 11'd0;
         pix_r       <= 8'd0;
         pix_g       <= 8'd0;
         pix_b       <= 8'd0;
         pix_de      <= 1'b0;
         pix_x       <= 10'd0;
         pix_y       <= 10'd0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         // Syncs are stored already normalised, so 1 always means asserted.
         s1_hs  <= (in_hs == SYNC_POL);
         s1_vs  <= (in_vs == SYNC_POL);
         s1_rgb <= {in_r, in_g, in_b};
         s2_hs  <= s1_hs;
         s2_vs  <= s1_vs;
         s2_rgb <= s1_rgb;

         if (hs_edge)
            h_cnt <= 12'd0;
         else if (h_cnt != 12'hFFF)
            h_cnt <= h_cnt + 12'd1;

         if (vs_edge)
            v_cnt <= 11'd0;
         else if (hs_edge)
            v_cnt <= v_cnt + 11'd1;

         case (state)
            UNLOCKED: begin
               skip_line <= 1'b1;
               if (vs_edge) begin
                  state    <= CHECK;
                  good_cnt <= 4'd0;
               end
            end
            CHECK: begin
               if (hs_edge)
                  skip_line <= 1'b0;
               if (line_bad) begin
                  state <= UNLOCKED;
               end else if (vs_edge) begin
                  if (frame_ok) begin
                     good_cnt <= good_cnt + 4'd1;
                     if ((good_cnt + 4'd1) == LF)
                        state <= LOCKED;
                  end else begin
                     good_cnt <= 4'd0;
                  end
               end
            end
            LOCKED: begin
               if (hs_edge)
                  skip_line <= 1'b0;
               if (line_bad || (vs_edge && !frame_ok))
                  state <= UNLOCKED;
            end
            default: state <= UNLOCKED;
         endcase

         pix_de      <= de_next;
         pix_x       <= h_cnt[9:0] - HA0[9:0];
         pix_y       <= v_cnt[9:0] - VA0[9:0];
         frame_start <= de_next && (h_cnt == HA0) && (v_cnt == VA0);
         pix_r       <= de_next ? s2_rgb[23:16] : 8'd0;
         pix_g       <= de_next ? s2_rgb[15:8]  : 8'd0;
         pix_b       <= de_next ? s2_rgb[7:0]   : 8'd0;
         locked      <= (state == LOCKED);
         // locked is still high for exactly the one cycle after state drops out of LOCKED.
         sync_err    <= locked && (state != LOCKED);
      end
   end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the display selector: consumes a VGA-style stream (hsync, vsync, 24-bit RGB) on `vga_clk` and recovers pixel coordinates, data-enable and frame/line markers from the sync pulses alone. It checks the stream against the configured timing and reports lock. When a source switch happens mid-frame, it drops lock instead of emitting misaligned pixels. It sits downstream of the mode mux, feeding capture, overlay or analysis logic that needs `pix_x`, `pix_y` and `pix_de` rather than raw syncs.

## Interface
- H_SYNC, 96, hsync pulse width in clocks
- H_BACK, 48, clocks from hsync end to first active pixel
- H_VALID, 640, active pixels per line (≤1024)
- H_TOTAL, 800, clocks per line
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, lines from vsync end to first active line
- V_VALID, 480, active lines (≤1024)
- V_TOTAL, 525, lines per frame
- SYNC_POL, 1, 1 = syncs active-high, 0 = active-low
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)
- vga_clk  in  1  pixel clock; the only clock
- sys_rst  in  1  synchronous, active-high reset
- in_hs  in  1  incoming hsync
- in_vs  in  1  incoming vsync
- in_r, in_g, in_b  in  8 each  incoming colour
- pix_r, pix_g, pix_b  out  8 each  pixel colour, aligned with pix_de
- pix_de  out  1  active pixel, only while locked
- pix_x  out  10  column 0..H_VALID-1, valid when pix_de
- pix_y  out  10  row 0..V_VALID-1, valid when pix_de
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- locked  out  1  timing verified
- sync_err  out  1  one-cycle pulse on loss of lock

## Operation
- Inputs are registered twice (s1, s2). Syncs are normalised by SYNC_POL to "asserted".
- hs_edge / vs_edge: asserted in s1 and not asserted in s2 (leading edge).
- h_cnt (12 b):
  - cleared on hs_edge, otherwise +1.
  - Saturates at 4095.
- v_cnt (11 b):
  - cleared on vs_edge, otherwise +1 on hs_edge.
  - When both edges occur in the same cycle, the vs_edge clear wins, and that line is line 0.
- Active region: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID) and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID).
  - pix_x = h_cnt − (H_SYNC+H_BACK).
  - pix_y = v_cnt − (V_SYNC+V_BACK).
- Line check: at each hs_edge, h_cnt+1 must equal H_TOTAL (ignored for the first hs_edge after UNLOCKED).
- Frame check: at each vs_edge, v_cnt+1 must equal V_TOTAL.
- Timeout: h_cnt reaching 2·H_TOTAL counts as a line mismatch.
- Lock FSM (state, good_cnt 4 b):
  - UNLOCKED: on vs_edge → CHECK, good_cnt=0.
  - CHECK:
    - Line mismatch or timeout → UNLOCKED.
    - vs_edge with frame match: good_cnt+1; if it equals LOCK_FRAMES → LOCKED, else stay in CHECK.
    - vs_edge with frame mismatch → CHECK, good_cnt=0.
  - LOCKED: any line/frame mismatch or timeout → UNLOCKED with sync_err=1 for one cycle.
- pix_de = active region AND state==LOCKED. frame_start = pix_de AND pix_x==0 AND pix_y==0.
- pix_r/g/b follow the s2 colour every cycle and are forced to 0 when pix_de=0.

## Timing
- Reset (sys_rst high at a clock edge): s1, s2, counters, good_cnt and all outputs go to 0; state goes to UNLOCKED. This applies also mid-frame.
- Latency: a colour sampled on in_* at clock k appears on pix_r/g/b at k+3. Its pix_x equals (k − k0) − (H_SYNC+H_BACK), where k0 is the clock at which the hsync leading edge was sampled.
- locked rises at k+3, where k is the clock at which the frame-completing vsync leading edge was sampled. It falls at the same relative cycle as the failing edge.
- sync_err is coincident with the falling edge of locked. There is no sync_err for failures in CHECK.
- The first line after a vs_edge transition into LOCKED already carries pix_de.
- Hold-off: a stream change takes effect within one line (line check) or one frame (frame check). No misaligned pix_de is emitted once the failure is detected.

## Test plan
- Reset mid-frame: sys_rst high for 3 cycles while locked → next cycle pix_*/locked/frame_start/sync_err all 0; relocks after 2 good frames.
- Clean 800×525 stream, SYNC_POL=1, pixel value = {x[7:0], y[7:0], 8'hA5}:
  - locked rises 3 cycles after the vsync edge that ends frame 2.
  - Frame 3 gives exactly 307200 pix_de cycles and one frame_start, at pix_x=0, pix_y=0.
  - Colour matches stimulus with 3-cycle latency.
- One 801-clock line while locked → sync_err one cycle at that hs_edge+3; locked=0; pix_de stays 0 until 2 further good frames.
- 524-line frame while locked → unlock and sync_err at that vsync edge+3.
- hsync held idle 1600 clocks while locked → timeout unlock and sync_err; a resumed clean stream relocks.
- SYNC_POL=0 with an inverted-sync stream → identical pix_x/pix_y/pix_de sequence to the clean-stream case.
